fwd_frame_serializer: RTL and testbench

- Receiving end of the data-forward frame path. Captures one parallel frame of number_words x 64-bit words from an upstream accelerator stage's forward bundle (rdy + data array).
- Streams the captured frame out word by word on a decoupled valid/ready master, with a last marker.
- Sits between a DCT/FFT stage's forward output and a FIFO-controller producer port, for stages whose result must leave as a stream rather than feed the next stage directly.

---
 rtl/fwd_pkg.sv | 17 +
 rtl/fwd_frame_buf.sv | 28 ++
 rtl/fwd_frame_serializer.sv | 120 ++++++++++++
 tb/tb_fwd_frame_serializer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forward-frame serializer path.
// Holds the FSM state encoding, the drop counter width and the sign-extension helper.
`timescale 1ns/1ps
package fwd_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } fwd_state_t;

    localparam int FWD_DROP_W = 16;

    function automatic logic [63:0] sext32to64(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/fwd_frame_buf.sv
// Frame buffer: number_words x data_width registers with a parallel load port and an indexed read port.
// The contents are deliberately not reset; a frame is always loaded before any word is read.
`timescale 1ns/1ps
module fwd_frame_buf #(
    parameter int number_words = 8,
    parameter int data_width   = 64,
    localparam int IDX_W       = $clog2(number_words)
) (
    input  logic                               clk,
    input  logic                               load,
    input  logic [number_words*data_width-1:0] load_data,
    input  logic [IDX_W-1:0]                   rd_idx,
    output logic [data_width-1:0]              rd_data
);

    logic [data_width-1:0] mem_q [number_words];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < number_words; i++) begin
                mem_q[i] <= load_data[i*data_width +: data_width];
            end
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fwd_frame_serializer.sv
// Captures one parallel forward frame and streams it out word by word on a valid/ready master.
// Valid/ready: a word transfers in any cycle where out_valid and out_ready are both high; out_data/out_valid hold otherwise.
`timescale 1ns/1ps
module fwd_frame_serializer
    import fwd_pkg::*;
#(
    parameter int number_words = 8,
    parameter int data_width   = 64,
    parameter bit sext_lo32    = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               fwd_rdy,
    input  logic [number_words*data_width-1:0] fwd_data,
    output logic                               fwd_ack,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [data_width-1:0]              out_data,
    output logic                               out_last,
    output logic                               busy,
    output logic [FWD_DROP_W-1:0]              drop_cnt
);

    localparam int IDX_W = $clog2(number_words);

    fwd_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FWD_DROP_W-1:0]  drop_q, drop_d;
    logic                   rdy_prev_q;

    logic                   load;
    logic                   ack_raw;
    logic                   refuse;
    logic                   hs;
    logic                   at_last;
    logic [data_width-1:0]  rd_data;
    logic [data_width-1:0]  word_proc;

    fwd_frame_buf #(
        .number_words (number_words),
        .data_width   (data_width)
    ) u_buf (
        .clk       (clk),
        .load      (load),
        .load_data (fwd_data),
        .rd_idx    (idx_q),
        .rd_data   (rd_data)
    );

    assign hs      = (state_q == S_STREAM) && out_ready;
    assign at_last = (idx_q == IDX_W'(number_words - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ack_raw = 1'b0;
        refuse  = 1'b0;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (fwd_rdy) begin
                    load    = 1'b1;
                    ack_raw = 1'b1;
                    state_d = S_STREAM;
                    idx_d   = '0;
                end
            end
            S_STREAM: begin
                if (hs) begin
                    if (at_last) begin
                        idx_d = '0;
                        // A frame offered on the final handshake is taken at once: no idle bubble.
                        if (fwd_rdy) begin
                            load    = 1'b1;
                            ack_raw = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                refuse = fwd_rdy && !(hs && at_last);
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
        // Only the rising edge of a refused offer counts, so a held level is one drop.
        if (refuse && !rdy_prev_q && (drop_q != '1)) begin
            drop_d = drop_q + FWD_DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            drop_q     <= '0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            rdy_prev_q <= fwd_rdy;
        end
    end

    assign word_proc = sext_lo32 ? data_width'(sext32to64(rd_data[31:0])) : rd_data;

    assign fwd_ack   = ack_raw && rst_n;
    assign out_valid = (state_q == S_STREAM);
    assign busy      = (state_q == S_STREAM);
    assign out_last  = out_valid && at_last;
    assign out_data  = out_valid ? word_proc : '0;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fwd_frame_serializer.sv
// Bench for fwd_frame_serializer: directed frames, scoreboard queue of expected words, negedge monitor.
// A second instance with sext_lo32=1 and two words per frame covers the sign-extension path.
`timescale 1ns/1ps
module tb_fwd_frame_serializer;
    import fwd_pkg::*;

    localparam int NW = 8;
    localparam int DW = 64;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT 1 (pass-through words)
    logic                  fwd_rdy;
    logic [NW*DW-1:0]      fwd_data;
    logic                  fwd_ack;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic                  busy;
    logic [FWD_DROP_W-1:0] drop_cnt;

    // DUT 2 (sign-extending, 2 words)
    logic                  rdy2;
    logic [2*DW-1:0]       data2;
    logic                  ack2;
    logic                  valid2;
    logic                  ready2;
    logic [DW-1:0]         odata2;
    logic                  last2;
    logic                  busy2;
    logic [FWD_DROP_W-1:0] drop2;

    fwd_frame_serializer #(.number_words(NW), .data_width(DW), .sext_lo32(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .fwd_rdy(fwd_rdy), .fwd_data(fwd_data), .fwd_ack(fwd_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    fwd_frame_serializer #(.number_words(2), .data_width(DW), .sext_lo32(1'b1)) dut_sx (
        .clk(clk), .rst_n(rst_n), .fwd_rdy(rdy2), .fwd_data(data2), .fwd_ack(ack2),
        .out_valid(valid2), .out_ready(ready2), .out_data(odata2), .out_last(last2),
        .busy(busy2), .drop_cnt(drop2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW:0] exp_q[$];   // {last, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [63:0] base);
        for (int i = 0; i < NW; i++) fwd_data[i*DW +: DW] = base + 64'(i);
    endtask

    task automatic push_frame(input logic [63:0] base);
        for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), base + 64'(i)});
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 40) begin
            tick();
            c++;
        end
        check({name, "_timeout"}, (c < 40), 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // monitor / scoreboard
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    always @(negedge clk) begin
        logic [DW:0] e;
        if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, stall_data);
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_data, 64'hx);
            end else begin
                e = exp_q.pop_front();
                check("word_data", out_data, e[DW-1:0]);
                check("word_last", out_last, e[DW]);
            end
        end
        if (!out_valid) check("data_zero_idle", out_data, 0);
        stall_prev = rst_n && out_valid && !out_ready;
        stall_data = out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; fwd_rdy = 1'b0; fwd_data = '0; out_ready = 1'b1;
        rdy2 = 1'b0; data2 = '0; ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ack", fwd_ack, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        // single frame, out_ready held high
        set_frame(64'h10); push_frame(64'h10); fwd_rdy = 1'b1;
        @(negedge clk);
        check("t1_ack", fwd_ack, 1);
        check("t1_valid_pre", out_valid, 0);
        tick();
        fwd_rdy = 1'b0;
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            check("t1_valid", out_valid, 1);
            check("t1_busy", busy, 1);
            check("t1_no_ack", fwd_ack, 0);
            tick();
        end
        @(negedge clk);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_valid", out_valid, 0);
        check("t1_queue_empty", exp_q.size(), 0);
        tick();

        // toggling out_ready; bit 31 set in every word must pass unchanged
        set_frame(64'hDEAD_BEEF_8000_0000); push_frame(64'hDEAD_BEEF_8000_0000); fwd_rdy = 1'b1;
        tick();
        fwd_rdy = 1'b0;
        begin
            int c;
            c = 0;
            out_ready = 1'b1;
            while (exp_q.size() > 0 && c < 40) begin
                tick();
                out_ready = ~out_ready;
                c++;
            end
            check("t2_cycles", c, 15);
        end
        out_ready = 1'b1;
        check("t2_idle", busy, 0);
        tick();

        // back-to-back frame offered on the last handshake
        set_frame(64'h10); push_frame(64'h10); fwd_rdy = 1'b1;
        tick();
        fwd_rdy = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (k == NW - 1) begin
                set_frame(64'h20); push_frame(64'h20); fwd_rdy = 1'b1;
            end
            @(negedge clk);
            check("t3_ack", fwd_ack, (k == NW - 1));
            tick();
        end
        fwd_rdy = 1'b0;
        @(negedge clk);
        check("t3_no_bubble_valid", out_valid, 1);
        check("t3_no_bubble_data", out_data, 64'h20);
        check("t3_drop", drop_cnt, 0);
        tick();
        wait_idle("t3");

        // drops: held level over 3 cycles, then a separate pulse
        set_frame(64'h40); push_frame(64'h40); fwd_rdy = 1'b1;
        tick();
        fwd_rdy = 1'b0;
        set_frame(64'h990);
        for (int k = 0; k < NW; k++) begin
            fwd_rdy = (k == 1 || k == 2 || k == 3 || k == 5);
            @(negedge clk);
            check("t4_no_ack", fwd_ack, 0);
            tick();
        end
        fwd_rdy = 1'b0;
        check("t4_drop", drop_cnt, 2);
        check("t4_idle", busy, 0);
        check("t4_queue_empty", exp_q.size(), 0);

        // reset mid-stream after word 3 handshakes
        set_frame(64'h50); push_frame(64'h50); fwd_rdy = 1'b1;
        tick();
        fwd_rdy = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_drop", drop_cnt, 0);
        check("t5_data", out_data, 0);
        tick();
        set_frame(64'h60); push_frame(64'h60); fwd_rdy = 1'b1;
        tick();
        fwd_rdy = 1'b0;
        @(negedge clk);
        check("t5_restart_data", out_data, 64'h60);
        tick();
        wait_idle("t5");

        // sign extension on the second instance
        data2 = {64'h0000_0000_7FFF_FFFF, 64'hDEAD_BEEF_8000_0001};
        rdy2 = 1'b1;
        @(negedge clk);
        check("t6_ack", ack2, 1);
        tick();
        rdy2 = 1'b0;
        @(negedge clk);
        check("t6_valid", valid2, 1);
        check("t6_w0", odata2, 64'hFFFF_FFFF_8000_0001);
        check("t6_w0_last", last2, 0);
        tick();
        @(negedge clk);
        check("t6_w1", odata2, 64'h0000_0000_7FFF_FFFF);
        check("t6_w1_last", last2, 1);
        tick();
        @(negedge clk);
        check("t6_idle", valid2, 0);
        check("t6_drop", drop2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
